// File: rtl/ibex_alu_pext_seq64_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_alu_pext_seq64_if
// Description : Request, register-file and shared-adder bundle for the 64-bit
//               P-extension add/sub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_alu_pext_seq64_if;
    logic        en_i;
    logic        kill_i;
    logic [3:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        rf_sel_hi_o;
    logic        adder_req_o;
    logic [31:0] adder_a_o;
    logic [31:0] adder_b_o;
    logic        adder_cin_o;
    logic [32:0] adder_result_i;
    logic [31:0] result_o;
    logic        wb_valid_o;
    logic        wb_hi_o;
    logic        valid_o;
    logic        ov_o;
    logic        busy_o;

    modport slave (
        input  en_i, kill_i, op_i, operand_a_i, operand_b_i, adder_result_i,
        output rf_sel_hi_o, adder_req_o, adder_a_o, adder_b_o, adder_cin_o,
               result_o, wb_valid_o, wb_hi_o, valid_o, ov_o, busy_o
    );

    modport master (
        output en_i, kill_i, op_i, operand_a_i, operand_b_i, adder_result_i,
        input  rf_sel_hi_o, adder_req_o, adder_a_o, adder_b_o, adder_cin_o,
               result_o, wb_valid_o, wb_hi_o, valid_o, ov_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_alu_pext_seq64.sv
`default_nettype none
// ============================================================================
// Module      : ibex_alu_pext_seq64
// Description : Two-beat sequencer for RV32 P-ext 64-bit add/sub (wrap,
//               halving, saturating) on register pairs via the shared adder.
//               Saturation is built only with IBEX_PEXT_SEQ64_SAT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_alu_pext_seq64 (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ibex_alu_pext_seq64_if.slave          bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_hi    = 2'd1;
    localparam logic [1:0] c_st_wb_lo = 2'd2;
    localparam logic [1:0] c_st_wb_hi = 2'd3;

    localparam logic [1:0] c_mode_half = 2'b01;
    localparam logic [1:0] c_mode_sat  = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_sum_lo;
    logic [31:0] r_sum_hi;
    logic        r_c_lo;
    logic        r_bit64;

    logic        w_abort;
    logic        w_accept;
    logic        w_in_hi;
    logic        w_sub;
    logic        w_ext_a;
    logic        w_ext_b;
    logic        w_bit64;
    logic [63:0] w_res_wrap;
    logic [63:0] w_res_half;
    logic [63:0] w_final;
    logic        w_sat;
    logic        w_wb_lo;
    logic        w_wb_hi;

    // en_i dropping mid-op means the ID stage abandoned the instruction.
    assign w_abort  = bus.kill_i
                    | (!bus.en_i && (r_state == c_st_hi || r_state == c_st_wb_lo));
    assign w_accept = (r_state == c_st_idle) && bus.en_i && !bus.kill_i && rst_ni;
    assign w_in_hi  = (r_state == c_st_hi) && !w_abort;
    assign w_sub    = w_accept ? bus.op_i[0] : r_op[0];

    assign bus.rf_sel_hi_o = (r_state == c_st_hi);
    assign bus.adder_req_o = w_accept | w_in_hi;
    assign bus.adder_a_o   = bus.adder_req_o ? bus.operand_a_i : 32'd0;
    assign bus.adder_b_o   = bus.adder_req_o ? (bus.operand_b_i ^ {32{w_sub}}) : 32'd0;
    assign bus.adder_cin_o = w_accept ? bus.op_i[0] : (w_in_hi ? r_c_lo : 1'b0);

    // Bit 64 of the exact 65-bit result: extension bits of both operands
    // (B's already inverted for sub) plus the carry out of bit 63.
    assign w_ext_a = r_op[1] & bus.operand_a_i[31];
    assign w_ext_b = (r_op[1] & bus.operand_b_i[31]) ^ r_op[0];
    assign w_bit64 = w_ext_a ^ w_ext_b ^ bus.adder_result_i[32];

    assign w_res_wrap = {r_sum_hi, r_sum_lo};
    assign w_res_half = {r_bit64, r_sum_hi, r_sum_lo[31:1]};

`ifdef IBEX_PEXT_SEQ64_SAT_EN
    logic        w_ovf_signed;
    logic        w_ovf_unsigned;
    logic [63:0] w_sat_val;

    assign w_ovf_signed   = r_op[1] & (r_bit64 != r_sum_hi[31]);
    assign w_ovf_unsigned = !r_op[1] & r_bit64;
    assign w_sat          = (r_op[3:2] == c_mode_sat) & (w_ovf_signed | w_ovf_unsigned);
    // Signed clamps toward the sign of the true result; unsigned add clamps
    // high, unsigned sub (negative result) clamps to zero.
    assign w_sat_val = r_op[1] ? (r_bit64 ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                               : (r_op[0] ? 64'd0 : {64{1'b1}});
    assign w_final   = w_sat ? w_sat_val
                     : (r_op[3:2] == c_mode_half) ? w_res_half : w_res_wrap;
`else
    assign w_sat   = 1'b0;
    assign w_final = (r_op[3:2] == c_mode_half) ? w_res_half : w_res_wrap;
`endif

    assign w_wb_lo = (r_state == c_st_wb_lo) && !w_abort;
    assign w_wb_hi = (r_state == c_st_wb_hi) && !w_abort;

    assign bus.wb_valid_o = w_wb_lo | w_wb_hi;
    assign bus.wb_hi_o    = w_wb_hi;
    assign bus.valid_o    = w_wb_hi;
    assign bus.ov_o       = w_wb_hi & w_sat;
    assign bus.result_o   = w_wb_hi ? w_final[63:32] : (w_wb_lo ? w_final[31:0] : 32'd0);
    assign bus.busy_o     = (r_state != c_st_idle);

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (w_accept) w_state_nxt = c_st_hi;
                c_st_hi:    w_state_nxt = c_st_wb_lo;
                c_st_wb_lo: w_state_nxt = c_st_wb_hi;
                c_st_wb_hi: w_state_nxt = c_st_idle;
                default:    w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= c_st_idle;
            r_op     <= 4'd0;
            r_sum_lo <= 32'd0;
            r_sum_hi <= 32'd0;
            r_c_lo   <= 1'b0;
            r_bit64  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= bus.op_i;
                r_sum_lo <= bus.adder_result_i[31:0];
                r_c_lo   <= bus.adder_result_i[32];
            end
            if (w_in_hi) begin
                r_sum_hi <= bus.adder_result_i[31:0];
                r_bit64  <= w_bit64;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibex_alu_pext_seq64.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_alu_pext_seq64
// Description : Randomized self-checking bench with a 66-bit arithmetic model
//               of the 64-bit add/sub group; honours IBEX_PEXT_SEQ64_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_alu_pext_seq64;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    ibex_alu_pext_seq64_if bus ();

    ibex_alu_pext_seq64 dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    logic [63:0] cur_a = 64'd0;
    logic [63:0] cur_b = 64'd0;

    // Register-file read ports and the shared adder, as the core provides them.
    assign bus.operand_a_i    = bus.rf_sel_hi_o ? cur_a[63:32] : cur_a[31:0];
    assign bus.operand_b_i    = bus.rf_sel_hi_o ? cur_b[63:32] : cur_b[31:0];
    assign bus.adder_result_i = {1'b0, bus.adder_a_o} + {1'b0, bus.adder_b_o}
                              + {32'd0, bus.adder_cin_o};

    typedef struct {
        int          t;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] last_lo;
    logic [31:0] last_hi;
    logic        last_ov;
    logic        last_cin_hi;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural reference: returns {ov, result[63:0]}.
    function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [65:0] ea, eb, r, lim_hi, lim_lo, umax;
        logic [63:0] res;
        logic        ov;
        ea     = op[1] ? {{2{a[63]}}, a} : {2'b00, a};
        eb     = op[1] ? {{2{b[63]}}, b} : {2'b00, b};
        r      = op[0] ? ea - eb : ea + eb;
        lim_hi = 66'(64'h7FFF_FFFF_FFFF_FFFF);
        lim_lo = -lim_hi - 66'sd1;
        umax   = 66'(64'hFFFF_FFFF_FFFF_FFFF);
        res    = r[63:0];
        ov     = 1'b0;
        if (op[3:2] == 2'b01) begin
            res = r[64:1];
        end
`ifdef IBEX_PEXT_SEQ64_SAT_EN
        else if (op[3:2] == 2'b10) begin
            if (op[1]) begin
                if (r > lim_hi) begin res = 64'h7FFF_FFFF_FFFF_FFFF; ov = 1'b1; end
                else if (r < lim_lo) begin res = 64'h8000_0000_0000_0000; ov = 1'b1; end
            end else if (!op[0] && r > umax) begin
                res = {64{1'b1}}; ov = 1'b1;
            end else if (op[0] && r < 0) begin
                res = 64'd0; ov = 1'b1;
            end
        end
`endif
        return {ov, res};
    endfunction

    function automatic logic carry_lo(input logic [3:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
        logic [32:0] s;
        s = {1'b0, a[31:0]} + {1'b0, (op[0] ? ~b[31:0] : b[31:0])} + {32'd0, op[0]};
        return s[32];
    endfunction

    // Single compare process: every cycle, outputs against the in-flight op.
    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("reset_outputs",
                {bus.wb_valid_o, bus.valid_o, bus.busy_o, bus.adder_req_o, bus.rf_sel_hi_o,
                 bus.ov_o, bus.wb_hi_o, bus.result_o, bus.adder_a_o, bus.adder_b_o},
                96'd0);
        end else if (q.size() == 0) begin
            chk("idle_quiet", {bus.wb_valid_o, bus.valid_o, bus.busy_o, bus.adder_req_o}, 96'd0);
        end else begin
            txn_t        x;
            int          d;
            logic [64:0] e;
            logic        abort;
            x     = q[0];
            d     = cyc - x.t;
            e     = model(x.op, x.a, x.b);
            abort = bus.kill_i | (!bus.en_i && (d == 1 || d == 2));
            case (d)
                0: chk("accept_ctl",
                       {bus.adder_req_o, bus.rf_sel_hi_o, bus.adder_cin_o, bus.busy_o, bus.wb_valid_o},
                       {1'b1, 1'b0, x.op[0], 1'b0, 1'b0});
                1: begin
                    chk("hi_ctl", {bus.rf_sel_hi_o, bus.busy_o, bus.wb_valid_o}, {1'b1, 1'b1, 1'b0});
                    if (!abort) begin
                        chk("hi_adder", {bus.adder_req_o, bus.adder_cin_o},
                            {1'b1, carry_lo(x.op, x.a, x.b)});
                        last_cin_hi = bus.adder_cin_o;
                    end
                end
                2: begin
                    chk("wb_lo_valid", {bus.busy_o, bus.wb_valid_o}, {1'b1, !abort});
                    if (!abort) begin
                        chk("wb_lo_data", {bus.wb_hi_o, bus.valid_o, bus.result_o},
                            {1'b0, 1'b0, e[31:0]});
                        last_lo = bus.result_o;
                    end
                end
                3: begin
                    chk("wb_hi_valid", {bus.busy_o, bus.wb_valid_o, bus.valid_o},
                        {1'b1, !bus.kill_i, !bus.kill_i});
                    if (!bus.kill_i) begin
                        chk("wb_hi_data", {bus.wb_hi_o, bus.ov_o, bus.result_o},
                            {1'b1, e[64], e[63:32]});
                        last_hi = bus.result_o;
                        last_ov = bus.ov_o;
                    end
                    void'(q.pop_front());
                end
                default: begin
                    chk("stale_txn", 96'(d), 96'd3);
                    void'(q.pop_front());
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kill_mode: 0 none, 1 kill in HI, 2 kill in WB_LO, 3 en low in HI,
    // 4 kill together with the start request.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int kill_mode, input bit b2b);
        txn_t x;
        cur_a = a;
        cur_b = b;
        bus.op_i   = op;
        bus.en_i   = 1'b1;
        bus.kill_i = (kill_mode == 4);
        if (kill_mode != 4) begin
            x.t = cyc; x.op = op; x.a = a; x.b = b;
            q.push_back(x);
        end
        step();
        if (kill_mode == 4) begin
            bus.kill_i = 1'b0;
            bus.en_i   = 1'b0;
            return;
        end
        bus.op_i = 4'($urandom);
        if (kill_mode == 1) bus.kill_i = 1'b1;
        if (kill_mode == 3) bus.en_i = 1'b0;
        if (kill_mode == 1 || kill_mode == 3) begin
            @(posedge clk);
            q.delete();
            #1;
            bus.kill_i = 1'b0;
            bus.en_i   = 1'b0;
            return;
        end
        step();
        if (kill_mode == 2) begin
            bus.kill_i = 1'b1;
            @(posedge clk);
            q.delete();
            #1;
            bus.kill_i = 1'b0;
            bus.en_i   = 1'b0;
            return;
        end
        step();
        step();
        if (!b2b) bus.en_i = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [31:0] lo, input logic [31:0] hi,
                            input logic ov);
        last_lo = 32'hDEAD_BEEF;
        last_hi = 32'hDEAD_BEEF;
        last_ov = 1'bx;
        run_op(op, a, b, 0, 1'b0);
        chk(name, {last_lo, last_hi, 31'd0, last_ov}, {lo, hi, 31'd0, ov});
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 6)
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_i   = 1'b0;
        bus.kill_i = 1'b0;
        bus.op_i   = 4'd0;
        repeat (2) @(posedge clk);
        #3 rst_ni = 1'b1;
        step();

        last_cin_hi = 1'b0;
        directed("add64_carry", 4'b0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 32'h0, 32'h1, 1'b0);
        chk("add64_hi_cin", {95'd0, last_cin_hi}, 96'd1);
        directed("sub64", 4'b0001, 64'd0, 64'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`ifdef IBEX_PEXT_SEQ64_SAT_EN
        directed("kadd64", 4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        directed("uksub64", 4'b1001, 64'd1, 64'd2, 32'h0, 32'h0, 1'b1);
`else
        directed("kadd64", 4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'h0, 32'h8000_0000, 1'b0);
        directed("uksub64", 4'b1001, 64'd1, 64'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`endif
        directed("radd64", 4'b0110, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 32'h0, 32'h8000_0000, 1'b0);
        directed("uradd64", 4'b0100, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 32'h0, 32'h8000_0000, 1'b0);

        // Kill in HI, one idle cycle, then a fresh op.
        run_op(4'b0000, 64'h1234_5678_9ABC_DEF0, 64'h1, 1, 1'b0);
        chk("kill_idle_busy", {95'd0, bus.busy_o}, 96'd0);
        step();
        directed("after_kill", 4'b0000, 64'h0000_0001_FFFF_FFFF, 64'h1, 32'h0, 32'h2, 1'b0);

        // Asynchronous reset in WB_LO.
        begin
            txn_t x;
            cur_a = 64'h0000_0005_0000_0007; cur_b = 64'h0000_0001_0000_0001;
            bus.op_i = 4'b0000; bus.en_i = 1'b1;
            x.t = cyc; x.op = 4'b0000; x.a = cur_a; x.b = cur_b;
            q.push_back(x);
            step();
            step();
            #2 rst_ni = 1'b0;
            q.delete();
            bus.en_i = 1'b0;
            #1;
            chk("async_rst_now", {bus.wb_valid_o, bus.valid_o, bus.busy_o, bus.wb_hi_o, bus.result_o},
                96'd0);
            @(posedge clk);
            #3 rst_ni = 1'b1;
            step();
            step();
        end

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            int         km;
            op = 4'($urandom);
            km = (($urandom % 8) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(op, pick(), pick(), km, bit'($urandom % 2));
        end
        bus.en_i = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
